// File: rtl/penc_seq.sv
// ---------------------------------------------------------------------------
// penc_seq -- sequential priority encoder
//
// Captures an N-bit request vector and emits the index of every set bit,
// one per output handshake, highest index first (lowest first when
// PENC_LSB_FIRST_EN is defined). An all-zero vector produces a single
// "empty" beat with VALID=0 so the consumer still sees one beat per vector.
//
// Configuration macro:
//   PENC_LSB_FIRST_EN  defined   -> lowest set index emitted first
//                      undefined -> highest set index emitted first
//
// Parameters:
//   N  request vector width (2..64)
//   W  index width, must equal $clog2(N)
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   A         request vector, sampled on in_vld && in_rdy
//   in_vld    A is valid
//   in_rdy    ready for a new vector (IDLE only)
//   Y         current index (0 when VALID=0)
//   VALID     beat carries a real index
//   out_vld   beat on Y/VALID/out_last is valid
//   out_rdy   consumer accepts the beat
//   out_last  final beat of the captured vector
//   pend      bits not yet serviced (registered)
// ---------------------------------------------------------------------------
module penc_seq #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] A,
   input  logic         in_vld,
   output logic         in_rdy,
   output logic [W-1:0] Y,
   output logic         VALID,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic         out_last,
   output logic [N-1:0] pend
);

   // Elaboration-time guard on the index width.
   if (W != $clog2(N)) begin : g_w_check
      $error("penc_seq: W must equal $clog2(N)");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      ZERO = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   pend_q, pend_d;
   logic [W-1:0]   sel_idx;
   logic [N-1:0]   sel_onehot;
   logic           single_bit;

   // Priority select over the pending bits. The last assignment in the loop
   // wins, so the loop direction sets the priority order.
   always_comb begin
      sel_idx = '0;
`ifdef PENC_LSB_FIRST_EN
      for (int i = N - 1; i >= 0; i--) begin
         if (pend_q[i]) sel_idx = W'(i);
      end
`else
      for (int i = 0; i < N; i++) begin
         if (pend_q[i]) sel_idx = W'(i);
      end
`endif
   end

   assign sel_onehot = N'(1) << sel_idx;

   // Exactly one bit left: nonzero and clearing the lowest set bit gives zero.
   assign single_bit = (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);

   // Next-state and output decode.
   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      in_rdy   = 1'b0;
      out_vld  = 1'b0;
      Y        = '0;
      VALID    = 1'b0;
      out_last = 1'b0;
      case (state_q)
         IDLE: begin
            in_rdy = 1'b1;
            if (in_vld) begin
               pend_d  = A;
               state_d = (A == '0) ? ZERO : EMIT;
            end
         end
         EMIT: begin
            out_vld  = 1'b1;
            VALID    = 1'b1;
            Y        = sel_idx;
            out_last = single_bit;
            if (out_rdy) begin
               pend_d = pend_q & ~sel_onehot;
               if (single_bit) state_d = IDLE;
            end
         end
         ZERO: begin
            out_vld  = 1'b1;
            out_last = 1'b1;
            if (out_rdy) state_d = IDLE;
         end
         default: begin
            // Unreachable encoding: recover to a clean IDLE.
            state_d = IDLE;
            pend_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   assign pend = pend_q;

endmodule

// File: tb/tb_penc_seq.sv
// ---------------------------------------------------------------------------
// tb_penc_seq -- scoreboard bench for penc_seq (N=8 and N=16 instances)
// ---------------------------------------------------------------------------
module tb_penc_seq;

   typedef struct {
      int          y;
      bit          valid;
      bit          last;
      logic [63:0] pend;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;

   // N=8 instance
   logic [7:0]  a8;
   logic        in_vld8, in_rdy8, valid8, out_vld8, out_rdy8, out_last8;
   logic [2:0]  y8;
   logic [7:0]  pend8;

   // N=16 instance
   logic [15:0] a16;
   logic        in_vld16, in_rdy16, valid16, out_vld16, out_rdy16, out_last16;
   logic [3:0]  y16;
   logic [15:0] pend16;

   int checks = 0;
   int errors = 0;

   beat_t sb8[$];
   beat_t sb16[$];

   always #5 clk = ~clk;

   penc_seq #(.N(8), .W(3)) u_dut8 (
      .clk(clk), .rst(rst), .A(a8), .in_vld(in_vld8), .in_rdy(in_rdy8),
      .Y(y8), .VALID(valid8), .out_vld(out_vld8), .out_rdy(out_rdy8),
      .out_last(out_last8), .pend(pend8)
   );

   penc_seq #(.N(16), .W(4)) u_dut16 (
      .clk(clk), .rst(rst), .A(a16), .in_vld(in_vld16), .in_rdy(in_rdy16),
      .Y(y16), .VALID(valid16), .out_vld(out_vld16), .out_rdy(out_rdy16),
      .out_last(out_last16), .pend(pend16)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: expected beat list for one captured vector.
   task automatic model_push(input logic [63:0] a, input int n, input bit wide);
      logic [63:0] p;
      beat_t       b;
      int          idx;
      p = a;
      if (p == 0) begin
         b.y = 0; b.valid = 0; b.last = 1; b.pend = 0;
         if (wide) sb16.push_back(b); else sb8.push_back(b);
      end else begin
         while (p != 0) begin
            idx = -1;
`ifdef PENC_LSB_FIRST_EN
            for (int i = 0; i < n; i++) if (p[i] && idx < 0) idx = i;
`else
            for (int i = n - 1; i >= 0; i--) if (p[i] && idx < 0) idx = i;
`endif
            b.y = idx; b.valid = 1; b.pend = p;
            b.last = ($countones(p) == 1);
            if (wide) sb16.push_back(b); else sb8.push_back(b);
            p[idx] = 1'b0;
         end
      end
   endtask

   // Output monitors: compare every accepted beat with the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_vld8 && out_rdy8) begin
         if (sb8.size() == 0) check_eq("n8_spurious_beat", 1, 0);
         else begin
            beat_t e;
            e = sb8.pop_front();
            check_eq("n8_y", y8, e.y);
            check_eq("n8_valid", valid8, e.valid);
            check_eq("n8_last", out_last8, e.last);
            check_eq("n8_pend", pend8, e.pend);
            $display("n8 beat y=%0d valid=%0b last=%0b pend=%08b", y8, valid8, out_last8, pend8);
         end
      end
      if (!rst && out_vld16 && out_rdy16) begin
         if (sb16.size() == 0) check_eq("n16_spurious_beat", 1, 0);
         else begin
            beat_t e;
            e = sb16.pop_front();
            check_eq("n16_y", y16, e.y);
            check_eq("n16_valid", valid16, e.valid);
            check_eq("n16_last", out_last16, e.last);
            check_eq("n16_pend", pend16, e.pend);
            $display("n16 beat y=%0d valid=%0b last=%0b pend=%04h", y16, valid16, out_last16, pend16);
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_in_rdy"}, in_rdy8, 1);
      check_eq({tag, "_out_vld"}, out_vld8, 0);
      check_eq({tag, "_y"}, y8, 0);
      check_eq({tag, "_valid"}, valid8, 0);
      check_eq({tag, "_last"}, out_last8, 0);
      check_eq({tag, "_pend"}, pend8, 0);
   endtask

   // Capture a vector on the N=8 instance; returns after the capture edge.
   task automatic capture8(input logic [7:0] a, input bit rdy);
      int guard;
      guard = 0;
      while (!in_rdy8 && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 50) check_eq("n8_in_rdy_timeout", 0, 1);
      a8 = a; in_vld8 = 1'b1; out_rdy8 = rdy;
      model_push({56'd0, a}, 8, 1'b0);
      @(posedge clk); #1;
      in_vld8 = 1'b0;
   endtask

   // Full-throughput vector: beats must come on consecutive cycles.
   task automatic run_vec8(input logic [7:0] a);
      int k, cyc;
      k = (a == 0) ? 1 : $countones(a);
      capture8(a, 1'b1);
      cyc = 0;
      while (sb8.size() > 0 && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      check_eq("n8_beat_cycles", cyc, k);
      @(negedge clk);
      check_eq("n8_turnaround_in_rdy", in_rdy8, 1);
      check_eq("n8_idle_out_vld", out_vld8, 0);
   endtask

   initial begin
      rst = 1'b1;
      a8 = '0; in_vld8 = 1'b0; out_rdy8 = 1'b0;
      a16 = '0; in_vld16 = 1'b0; out_rdy16 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Multi-bit vector at full rate, then the empty vector.
      run_vec8(8'b11001110);
      run_vec8(8'b00000000);

      // Backpressure: three stall cycles before each beat, with a
      // competing vector presented that must not be captured.
      begin
         int k;
         capture8(8'b00100110, 1'b0);
         k = sb8.size();
         for (int b = 0; b < k; b++) begin
            for (int s = 0; s < 3; s++) begin
               a8 = 8'hFF; in_vld8 = 1'b1;
               @(negedge clk);
               check_eq("stall_y_hold", y8, sb8[0].y);
               check_eq("stall_pend", pend8, sb8[0].pend);
               check_eq("stall_out_vld", out_vld8, 1);
               check_eq("stall_in_rdy", in_rdy8, 0);
               @(posedge clk); #1;
            end
            in_vld8 = 1'b0; out_rdy8 = 1'b1;
            @(posedge clk); #1;
            out_rdy8 = 1'b0;
         end
         @(negedge clk);
         check_eq("stall_sb_empty", sb8.size(), 0);
         check_eq("stall_end_pend", pend8, 0);
         check_eq("stall_end_in_rdy", in_rdy8, 1);
         check_eq("stall_no_capture", out_vld8, 0);
      end

      // Asynchronous reset after the second accepted beat.
      begin
         int guard;
         capture8(8'b10100110, 1'b1);
         guard = 0;
         while (sb8.size() > 2 && guard < 20) begin
            @(posedge clk); #1; guard++;
         end
         check_eq("midrst_two_beats", sb8.size(), 2);
         #1 rst = 1'b1;
         #1;
         check_reset_vals("midrst");
         sb8.delete();
         @(posedge clk); #1;
         rst = 1'b0;
         run_vec8(8'b00001110);
      end

      // Wide instance: index 15 and 0 at the extremes.
      begin
         int cyc;
         a16 = 16'h8001; in_vld16 = 1'b1; out_rdy16 = 1'b1;
         model_push({48'd0, 16'h8001}, 16, 1'b1);
         @(posedge clk); #1;
         in_vld16 = 1'b0;
         cyc = 0;
         while (sb16.size() > 0 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
         end
         check_eq("n16_beat_cycles", cyc, 2);
         @(negedge clk);
         check_eq("n16_in_rdy", in_rdy16, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
